// File: rtl/jam_pkg.sv
// jam_pkg
// Shared constants and types for the JAM cost-matrix loader.
//   N          : workers = jobs (matrix is N x N)
//   IDX_W      : width of a worker or job index
//   COST_W     : width of one cost word
//   SUM_W      : width of the running checksum (holds N*N*max cost)
//   MAT_BEATS  : number of load beats for a full matrix
//   state_t    : loader FSM states
package jam_pkg;

    localparam int N         = 8;
    localparam int IDX_W     = 3;
    localparam int ADDR_W    = 2 * IDX_W;
    localparam int COST_W    = 7;
    localparam int SUM_W     = 13;
    localparam int MAT_BEATS = N * N;

    // Address of the final beat; a handshake here completes the matrix.
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(MAT_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READY
    } state_t;

endpackage

// File: rtl/jam_cost_regfile.sv
// jam_cost_regfile
// 64-entry cost storage with one synchronous write port and one registered
// read port. A read and a write to the same address in the same cycle return
// the old contents; the new value is visible on the next read.
// Ports:
//   CLK    : clock
//   RST    : synchronous active-high reset (clears the read register only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : registered read data, one cycle after raddr
module jam_cost_regfile
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [COST_W-1:0] rdata
);

    logic [COST_W-1:0] mem [MAT_BEATS];

    // Storage array: matrix contents deliberately survive reset so they
    // can map onto plain RAM without a reset network.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: samples the pre-write array contents every cycle,
    // which is what gives the read-before-write behaviour.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/jam_cost_table.sv
// jam_cost_table
// Upstream cost-matrix stage for the JAM assignment engine. Loads an 8x8 cost
// matrix row-major over a valid/ready stream, holds the engine in reset while
// loading, then serves Cost lookups addressed by the engine's W/J outputs with
// one cycle of latency.
// Ports:
//   CLK       : clock
//   RST       : synchronous active-high reset
//   in_valid  : load beat valid
//   in_ready  : load beat accepted when in_valid & in_ready
//   in_data   : cost value, beat k -> worker k[5:3], job k[2:0]
//   reload    : request a fresh matrix load (only honoured in READY)
//   W, J      : worker / job index from the engine
//   Cost      : registered mem[{W,J}]
//   CORE_RST  : engine reset, high until the matrix is fully loaded
//   loaded    : matrix complete and stable
//   checksum  : sum of all loaded costs
module jam_cost_table
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_data,
    input  logic              reload,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    output logic              CORE_RST,
    output logic              loaded,
    output logic [SUM_W-1:0]  checksum
);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              beat_fire;

    // Status outputs decode straight from the state register, so the engine
    // reset never glitches and always covers at least one cycle after reload.
    assign in_ready  = (state == LOAD);
    assign CORE_RST  = (state != READY);
    assign loaded    = (state == READY);
    assign beat_fire = in_ready && in_valid;

    // Loader FSM with beat counter and checksum. Counter and checksum are
    // cleared on every entry to LOAD so a reload starts from a clean slate;
    // outside that the checksum simply holds its last value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= LOAD;
                    cnt      <= '0;
                    checksum <= '0;
                end
                LOAD: begin
                    if (in_valid) begin
                        cnt      <= cnt + ADDR_W'(1);
                        checksum <= checksum + {{(SUM_W - COST_W){1'b0}}, in_data};
                        if (cnt == LAST_BEAT) begin
                            state <= READY;
                        end
                    end
                end
                READY: begin
                    if (reload) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        checksum <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Beat k lands at address k, which is exactly {worker, job} for a
    // row-major stream, so the lookup address is just {W, J}.
    jam_cost_regfile u_regfile (
        .CLK   (CLK),
        .RST   (RST),
        .we    (beat_fire),
        .waddr (cnt),
        .wdata (in_data),
        .raddr ({W, J}),
        .rdata (Cost)
    );

endmodule

// File: tb/tb_jam_cost_table.sv
// tb_jam_cost_table
// Scoreboard bench for jam_cost_table: lookups push the expected Cost into a
// queue and a monitor pops and compares one cycle later. Status outputs are
// compared directly against hand-computed constants.
module tb_jam_cost_table;
    import jam_pkg::*;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [COST_W-1:0] in_data = '0;
    logic              reload = 1'b0;
    logic [IDX_W-1:0]  W = '0;
    logic [IDX_W-1:0]  J = '0;
    logic [COST_W-1:0] Cost;
    logic              CORE_RST;
    logic              loaded;
    logic [SUM_W-1:0]  checksum;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [COST_W-1:0] exp_q[$];
    logic [COST_W-1:0] exp_mem [MAT_BEATS];
    logic              look   = 1'b0;
    logic              look_d = 1'b0;

    jam_cost_table dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .reload   (reload),
        .W        (W),
        .J        (J),
        .Cost     (Cost),
        .CORE_RST (CORE_RST),
        .loaded   (loaded),
        .checksum (checksum)
    );

    always #5 CLK = ~CLK;

    // Delay the lookup flag by the DUT's read latency so the monitor knows
    // which cycles carry a Cost word to check.
    always @(posedge CLK) begin
        look_d <= look;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation for every cycle a lookup result is due.
    always @(negedge CLK) begin
        if (look_d) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL cost_scoreboard: got %0d, expected <queue empty>", Cost);
            end else begin
                checkOutput("cost", 32'(Cost), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input int w, input int j, input int exp);
        W    = IDX_W'(w);
        J    = IDX_W'(j);
        look = 1'b1;
        exp_q.push_back(COST_W'(exp));
        tick();
    endtask

    task automatic resetDut();
        look = 1'b0;
        RST  = 1'b1;
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_cost", 32'(Cost), 0);
        checkOutput("rst_core_rst", 32'(CORE_RST), 1);
        checkOutput("rst_loaded", 32'(loaded), 0);
        checkOutput("rst_checksum", 32'(checksum), 0);
        tick();
        RST = 1'b0;
    endtask

    task automatic reloadPulse();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        checkOutput("reload_core_rst", 32'(CORE_RST), 1);
        checkOutput("reload_loaded", 32'(loaded), 0);
        checkOutput("reload_checksum", 32'(checksum), 0);
        checkOutput("reload_in_ready", 32'(in_ready), 1);
    endtask

    function automatic logic [COST_W-1:0] beatValue(input int mode, input int k);
        case (mode)
            0:       return COST_W'(k);
            1:       return 7'd127;
            2:       return COST_W'(63 - k);
            default: return 7'd1;
        endcase
    endfunction

    // Streams nbeats accepted beats. With rbw set, every cycle also looks up
    // the address being written and expects the pre-write contents.
    task automatic loadMatrix(input int mode, input bit toggle, input int nbeats,
                              input int exp_ticks, input int exp_rdy, input bit rbw,
                              input int exp_sum);
        int k = 0;
        int ticks = 0;
        int rdy = 0;
        int early = 0;
        bit phase = 1'b1;
        bit accepted;
        logic [ADDR_W-1:0] a;
        while (k < nbeats && ticks < 400) begin
            in_valid = toggle ? phase : 1'b1;
            phase    = ~phase;
            in_data  = beatValue(mode, k);
            reload   = (k == 10);
            a        = k[ADDR_W-1:0];
            if (rbw) begin
                W    = a[5:3];
                J    = a[2:0];
                look = 1'b1;
                exp_q.push_back(exp_mem[a]);
            end
            if (loaded) early++;
            if (in_ready) rdy++;
            accepted = in_valid && in_ready;
            if (accepted) exp_mem[a] = in_data;
            tick();
            ticks++;
            if (accepted) k++;
        end
        in_valid = 1'b0;
        reload   = 1'b0;
        look     = 1'b0;
        checkOutput("load_beats", k, nbeats);
        checkOutput("load_early_done", early, 0);
        if (nbeats == MAT_BEATS) begin
            checkOutput("load_ticks", ticks, exp_ticks);
            checkOutput("load_ready_cycles", rdy, exp_rdy);
            checkOutput("done_loaded", 32'(loaded), 1);
            checkOutput("done_core_rst", 32'(CORE_RST), 0);
            checkOutput("done_in_ready", 32'(in_ready), 0);
            checkOutput("done_checksum", 32'(checksum), exp_sum);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < MAT_BEATS; i++) exp_mem[i] = '0;

        // Reset, then a straight 0..63 load with in_valid held high.
        resetDut();
        loadMatrix(0, 1'b0, 64, 65, 64, 1'b0, 2016);

        // Lookups: each result lags its address by one cycle.
        applyStimulus(3, 5, 29);
        applyStimulus(7, 7, 63);
        applyStimulus(0, 0, 0);
        applyStimulus(1, 2, 10);
        applyStimulus(6, 1, 49);
        applyStimulus(2, 7, 23);
        look = 1'b0;

        // Beats offered in READY must be ignored.
        in_valid = 1'b1;
        in_data  = 7'd100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("ready_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        applyStimulus(3, 5, 29);
        look = 1'b0;
        checkOutput("ready_checksum_held", 32'(checksum), 2016);

        // Reload with 63-k; reload is also pulsed mid-load and must be ignored.
        reloadPulse();
        loadMatrix(2, 1'b0, 64, 64, 64, 1'b1, 2016);
        applyStimulus(0, 0, 63);
        applyStimulus(7, 7, 0);
        applyStimulus(3, 5, 34);
        look = 1'b0;

        // All-127 load with in_valid toggling.
        reloadPulse();
        loadMatrix(1, 1'b1, 64, 127, 127, 1'b1, 8128);
        applyStimulus(4, 2, 127);
        applyStimulus(7, 0, 127);
        applyStimulus(0, 0, 127);
        look = 1'b0;

        // Reset after 20 beats, then a full load of ones.
        reloadPulse();
        loadMatrix(0, 1'b0, 20, 0, 0, 1'b1, 0);
        resetDut();
        loadMatrix(3, 1'b0, 64, 65, 64, 1'b1, 64);
        applyStimulus(0, 0, 1);
        applyStimulus(2, 4, 1);
        applyStimulus(7, 7, 1);
        look = 1'b0;

        tick();
        tick();
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
